// File: rtl/cbfp_normalize_if.sv
// cbfp_normalize_if: beat-level bus of the block-floating-point normaliser.
// slave is the normaliser's view, master the upstream/downstream view.
interface cbfp_normalize_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int IN_W          = 25,
   parameter int OUT_W         = 11,
   parameter int BLK_PER_FRAME = 32
);
   localparam int CW = $clog2(BLK_PER_FRAME);
   logic                    i_valid;
   logic signed [IN_W-1:0]  i_data_re [0:DATA_WIDTH-1];
   logic signed [IN_W-1:0]  i_data_im [0:DATA_WIDTH-1];
   logic [4:0]              i_min_cnt_0;
   logic [4:0]              i_min_cnt_1;
   logic                    o_valid;
   logic signed [OUT_W-1:0] o_data_re [0:DATA_WIDTH-1];
   logic signed [OUT_W-1:0] o_data_im [0:DATA_WIDTH-1];
   logic [4:0]              o_exp_0;
   logic [4:0]              o_exp_1;
   logic [CW-1:0]           o_blk_idx;
   logic                    o_last;
   modport master (
      output i_valid, i_data_re, i_data_im, i_min_cnt_0, i_min_cnt_1,
      input  o_valid, o_data_re, o_data_im, o_exp_0, o_exp_1, o_blk_idx, o_last
   );
   modport slave (
      input  i_valid, i_data_re, i_data_im, i_min_cnt_0, i_min_cnt_1,
      output o_valid, o_data_re, o_data_im, o_exp_0, o_exp_1, o_blk_idx, o_last
   );
endinterface

// File: rtl/cbfp_normalize.sv
// cbfp_normalize: per-half shift by common sign-bit count, reduce to OUT_W, 2-cycle latency, frame counter.
// Define CBFP_ROUND_EN for round-half-up with positive saturation instead of truncation.
module cbfp_normalize #(
   parameter int DATA_WIDTH    = 16,
   parameter int IN_W          = 25,
   parameter int OUT_W         = 11,
   parameter int MAX_SHIFT     = IN_W - OUT_W,
   parameter int BLK_PER_FRAME = 32
) (
   input logic clk,
   input logic rst,
   cbfp_normalize_if.slave bus
);
   localparam int D = IN_W - OUT_W;
   localparam int HALF = DATA_WIDTH / 2;
   localparam int CW = $clog2(BLK_PER_FRAME);
   localparam logic [CW-1:0] LAST_IDX = CW'(BLK_PER_FRAME - 1);

   logic                    s1_valid_q, s1_valid_d;
   logic signed [IN_W-1:0]  s1_re_q [0:DATA_WIDTH-1];
   logic signed [IN_W-1:0]  s1_re_d [0:DATA_WIDTH-1];
   logic signed [IN_W-1:0]  s1_im_q [0:DATA_WIDTH-1];
   logic signed [IN_W-1:0]  s1_im_d [0:DATA_WIDTH-1];
   logic [4:0]              s1_sh0_q, s1_sh0_d, s1_sh1_q, s1_sh1_d;
   logic [CW-1:0]           s1_idx_q, s1_idx_d, cnt_q, cnt_d;
   logic                    o_valid_q, o_valid_d, o_last_q, o_last_d;
   logic signed [OUT_W-1:0] o_re_q [0:DATA_WIDTH-1];
   logic signed [OUT_W-1:0] o_re_d [0:DATA_WIDTH-1];
   logic signed [OUT_W-1:0] o_im_q [0:DATA_WIDTH-1];
   logic signed [OUT_W-1:0] o_im_d [0:DATA_WIDTH-1];
   logic [4:0]              o_exp0_q, o_exp0_d, o_exp1_q, o_exp1_d;
   logic [CW-1:0]           o_idx_q, o_idx_d;

   function automatic logic [4:0] clamp(input logic [4:0] c);
      return (c > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : c;
   endfunction

   // The shift never exceeds the redundant sign bits, so x keeps IN_W bits losslessly.
   function automatic logic signed [OUT_W-1:0] reduce(input logic signed [IN_W-1:0] smp, input logic [4:0] s);
      logic signed [IN_W-1:0] x;
`ifdef CBFP_ROUND_EN
      logic signed [IN_W:0] r;
`endif
      x = smp <<< s;
`ifdef CBFP_ROUND_EN
      r = ($signed({x[IN_W-1], x}) + $signed((IN_W+1)'(2 ** (D - 1)))) >>> D;
      return (r > $signed((IN_W+1)'(2 ** (OUT_W - 1) - 1))) ? OUT_W'(2 ** (OUT_W - 1) - 1) : OUT_W'(r);
`else
      return OUT_W'(x >>> D);
`endif
   endfunction

   always_comb begin
      s1_valid_d = bus.i_valid;
      s1_sh0_d   = bus.i_valid ? clamp(bus.i_min_cnt_0) : s1_sh0_q;
      s1_sh1_d   = bus.i_valid ? clamp(bus.i_min_cnt_1) : s1_sh1_q;
      s1_idx_d   = bus.i_valid ? cnt_q : s1_idx_q;
      cnt_d      = bus.i_valid ? ((cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1) : cnt_q;
      o_valid_d  = s1_valid_q;
      o_last_d   = s1_valid_q && (s1_idx_q == LAST_IDX);
      o_exp0_d   = s1_valid_q ? s1_sh0_q : o_exp0_q;
      o_exp1_d   = s1_valid_q ? s1_sh1_q : o_exp1_q;
      o_idx_d    = s1_valid_q ? s1_idx_q : o_idx_q;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         s1_re_d[i] = bus.i_valid ? bus.i_data_re[i] : s1_re_q[i];
         s1_im_d[i] = bus.i_valid ? bus.i_data_im[i] : s1_im_q[i];
         o_re_d[i]  = s1_valid_q ? reduce(s1_re_q[i], (i < HALF) ? s1_sh0_q : s1_sh1_q) : o_re_q[i];
         o_im_d[i]  = s1_valid_q ? reduce(s1_im_q[i], (i < HALF) ? s1_sh0_q : s1_sh1_q) : o_im_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sh0_q   <= '0;
         s1_sh1_q   <= '0;
         s1_idx_q   <= '0;
         cnt_q      <= '0;
         o_valid_q  <= 1'b0;
         o_last_q   <= 1'b0;
         o_exp0_q   <= '0;
         o_exp1_q   <= '0;
         o_idx_q    <= '0;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            s1_re_q[i] <= '0;
            s1_im_q[i] <= '0;
            o_re_q[i]  <= '0;
            o_im_q[i]  <= '0;
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sh0_q   <= s1_sh0_d;
         s1_sh1_q   <= s1_sh1_d;
         s1_idx_q   <= s1_idx_d;
         cnt_q      <= cnt_d;
         o_valid_q  <= o_valid_d;
         o_last_q   <= o_last_d;
         o_exp0_q   <= o_exp0_d;
         o_exp1_q   <= o_exp1_d;
         o_idx_q    <= o_idx_d;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            s1_re_q[i] <= s1_re_d[i];
            s1_im_q[i] <= s1_im_d[i];
            o_re_q[i]  <= o_re_d[i];
            o_im_q[i]  <= o_im_d[i];
         end
      end
   end

   assign bus.o_valid   = o_valid_q;
   assign bus.o_data_re = o_re_q;
   assign bus.o_data_im = o_im_q;
   assign bus.o_exp_0   = o_exp0_q;
   assign bus.o_exp_1   = o_exp1_q;
   assign bus.o_blk_idx = o_idx_q;
   assign bus.o_last    = o_last_q;
endmodule

// File: tb/tb_cbfp_normalize.sv
// tb_cbfp_normalize: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cbfp_normalize;
   localparam int N = 16;
`ifdef CBFP_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cbfp_normalize_if #(.DATA_WIDTH(N), .IN_W(25), .OUT_W(11), .BLK_PER_FRAME(32)) bus ();
   cbfp_normalize #(.DATA_WIDTH(N), .IN_W(25), .OUT_W(11), .BLK_PER_FRAME(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [N-1:0][10:0] re;
      logic [N-1:0][10:0] im;
      logic [4:0]         e0;
      logic [4:0]         e1;
      logic [4:0]         idx;
      logic               last;
      int                 cyc;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   exp_t last_e;
   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [4:0] nidx = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   function automatic exp_t blank();
      exp_t b;
      b.re = '0;
      b.im = '0;
      b.e0 = '0;
      b.e1 = '0;
      b.idx = '0;
      b.last = 1'b0;
      b.cyc = 0;
      return b;
   endfunction

   // Reference: multiply by 2^s and floor-divide in 64-bit arithmetic.
   function automatic logic [10:0] ref_out(input longint v, input int s);
      longint x;
      longint q;
      x = v * (longint'(1) << s);
      q = RND ? ((x + 8192) >>> 14) : (x >>> 14);
      if (q > 1023) q = 1023;
      return 11'(q);
   endfunction

   task automatic clear_in();
      bus.i_valid = 1'b0;
      bus.i_min_cnt_0 = '0;
      bus.i_min_cnt_1 = '0;
      for (int i = 0; i < N; i++) begin
         bus.i_data_re[i] = '0;
         bus.i_data_im[i] = '0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " o_valid"}, 64'(bus.o_valid), 0);
      chk({tag, " o_last"}, 64'(bus.o_last), 0);
      chk({tag, " o_exp_0"}, 64'(bus.o_exp_0), 0);
      chk({tag, " o_exp_1"}, 64'(bus.o_exp_1), 0);
      chk({tag, " o_blk_idx"}, 64'(bus.o_blk_idx), 0);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s re[%0d]", tag, i), $signed(bus.o_data_re[i]), 0);
         chk($sformatf("%s im[%0d]", tag, i), $signed(bus.o_data_im[i]), 0);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk_zero(tag);
      sb.delete();
      nidx = '0;
      last_e = blank();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic issue(input exp_t e);
      e.cyc = cyc;
      e.idx = nidx;
      e.last = (nidx == 5'd31);
      nidx = nidx + 5'd1;
      bus.i_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.i_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_beat();
      exp_t e;
      int s[2];
      int c[2];
      logic signed [24:0] r;
      logic signed [24:0] m;
      e = blank();
      for (int h = 0; h < 2; h++) begin
         s[h] = $urandom_range(0, 14);
         c[h] = $urandom_range(0, s[h]);
      end
      bus.i_min_cnt_0 = 5'(c[0]);
      bus.i_min_cnt_1 = 5'(c[1]);
      e.e0 = 5'(c[0]);
      e.e1 = 5'(c[1]);
      for (int i = 0; i < N; i++) begin
         r = 25'($urandom);
         m = 25'($urandom);
         r = r >>> s[i / 8];
         m = m >>> s[i / 8];
         bus.i_data_re[i] = r;
         bus.i_data_im[i] = m;
         e.re[i] = ref_out(longint'(r), c[i / 8]);
         e.im[i] = ref_out(longint'(m), c[i / 8]);
      end
      issue(e);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_valid) begin
            if (sb.size() == 0) chk("unexpected o_valid", 1, 0);
            else begin
               me = sb.pop_front();
               chk($sformatf("latency idx%0d", me.idx), 64'(cyc - me.cyc), 2);
               chk($sformatf("o_blk_idx idx%0d", me.idx), 64'(bus.o_blk_idx), 64'(me.idx));
               chk($sformatf("o_last idx%0d", me.idx), 64'(bus.o_last), 64'(me.last));
               chk($sformatf("o_exp_0 idx%0d", me.idx), 64'(bus.o_exp_0), 64'(me.e0));
               chk($sformatf("o_exp_1 idx%0d", me.idx), 64'(bus.o_exp_1), 64'(me.e1));
               for (int i = 0; i < N; i++) begin
                  chk($sformatf("re[%0d] idx%0d", i, me.idx), $signed(bus.o_data_re[i]), $signed(me.re[i]));
                  chk($sformatf("im[%0d] idx%0d", i, me.idx), $signed(bus.o_data_im[i]), $signed(me.im[i]));
               end
               last_e = me;
            end
         end else begin
            chk("hold o_last", 64'(bus.o_last), 0);
            chk("hold o_exp_0", 64'(bus.o_exp_0), 64'(last_e.e0));
            chk("hold o_exp_1", 64'(bus.o_exp_1), 64'(last_e.e1));
            chk("hold o_blk_idx", 64'(bus.o_blk_idx), 64'(last_e.idx));
            chk("hold re[0]", $signed(bus.o_data_re[0]), $signed(last_e.re[0]));
            chk("hold im[15]", $signed(bus.o_data_im[15]), $signed(last_e.im[15]));
         end
      end
   end

   initial begin
      exp_t e;
      clear_in();
      last_e = blank();
      #1;
      do_reset("reset");
      // clamped shift: 23 -> 14, 1<<14 reduces to 1
      e = blank();
      bus.i_data_re[0] = 25'sd1;
      bus.i_min_cnt_0 = 5'd23;
      e.re[0] = 11'd1;
      e.e0 = 5'd14;
      issue(e);
      // per-half shifts
      clear_in();
      e = blank();
      bus.i_data_re[0] = -25'sd4096;
      bus.i_data_re[8] = -25'sd4096;
      bus.i_min_cnt_0 = 5'd12;
      e.re[0] = 11'h400;
      e.re[8] = RND ? 11'h000 : 11'h7FF;
      e.e0 = 5'd12;
      issue(e);
      // reduction edge values at shift 0
      clear_in();
      e = blank();
      bus.i_data_re[0] = 25'sd8192;
      bus.i_data_re[1] = 25'h0FFFFFF;
      bus.i_data_re[2] = -25'sd1;
      bus.i_data_im[3] = 25'h1000000;
      e.re[0] = RND ? 11'd1 : 11'd0;
      e.re[1] = 11'd1023;
      e.re[2] = RND ? 11'h000 : 11'h7FF;
      e.im[3] = 11'h400;
      issue(e);
      clear_in();
      idle(4);
      // two back-to-back frames
      do_reset("reset2");
      for (int k = 0; k < 64; k++) rand_beat();
      // random bubbles must not advance the index
      for (int k = 0; k < 40; k++) begin
         rand_beat();
         idle($urandom_range(0, 3));
      end
      idle(4);
      // reset while beat 10 is presented and beats 8, 9 are in flight
      do_reset("reset3");
      for (int k = 0; k < 10; k++) rand_beat();
      bus.i_valid = 1'b1;
      do_reset("reset mid-frame");
      clear_in();
      idle(3);
      rand_beat();
      rand_beat();
      clear_in();
      for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
      #1;
      chk("drain", 64'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cbfp_normalize.md
# cbfp_normalize

Block-floating-point normaliser for the pipelined FFT datapath, placed directly after the min-count detector. Each beat carries 16 complex lanes. For each half of the lanes (lanes 0..7 and 8..15), the block left-shifts every sample by the half's common redundant-sign-bit count, then reduces the result to the output width. The applied shift is emitted as a per-half exponent for later denormalisation. A block counter marks frame boundaries.

## Interface
- DATA_WIDTH, 16: lanes per beat (even); half = DATA_WIDTH/2
- IN_W, 25: input sample width, signed
- OUT_W, 11: output sample width, signed
- MAX_SHIFT, IN_W-OUT_W: upper clamp on applied shift
- BLK_PER_FRAME, 32: beats per frame; counter width = $clog2(BLK_PER_FRAME)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  beat qualifier
- i_data_re / i_data_im  in  [0:DATA_WIDTH-1] x IN_W signed  input samples
- i_min_cnt_0 / i_min_cnt_1  in  5 unsigned  common count for the lower / upper half, same cycle as data
- o_valid  out  1  output qualifier
- o_data_re / o_data_im  out  [0:DATA_WIDTH-1] x OUT_W signed  normalised samples
- o_exp_0 / o_exp_1  out  5 unsigned  shift applied to the lower / upper half
- o_blk_idx  out  $clog2(BLK_PER_FRAME)  beat index within frame
- o_last  out  1  high with the final beat of a frame

## Operation
- **Stage 1 (on i_valid):**
  - Register all lane data.
  - Register per-half shift s = min(i_min_cnt_h, MAX_SHIFT).
  - Capture the current block index.
- **Stage 2:**
  - For each lane, compute x = data <<< s, held at IN_W bits. This is lossless because s never exceeds the redundant sign bits.
  - Reduce x by dropping the low D = IN_W-OUT_W bits.
  - Default reduction is truncation: arithmetic >>> D (floor).
  - Register outputs. o_exp_h = s.
- **Block counter:**
  - Increments on every accepted i_valid beat and wraps from BLK_PER_FRAME-1 to 0.
  - o_last = (o_blk_idx == BLK_PER_FRAME-1) && o_valid.
- **No backpressure:** every i_valid beat produces exactly one o_valid beat.
- **Bubbles:** i_valid low produces a bubble. Stages hold their data, o_valid drops, and the counter holds.

## Timing
- Latency is 2 cycles from i_valid to o_valid, fully pipelined, one beat per cycle.
- Reset values: o_valid=0, o_data_*=0, o_exp_*=0, o_blk_idx=0, o_last=0, internal counter=0, stage valids=0.
- Reset asserted mid-frame:
  - Flushes both stages and no beat emerges.
  - After deassertion, the next beat is index 0.
- i_min_cnt_h > MAX_SHIFT: clamped to MAX_SHIFT, and o_exp_h reports the clamped value.
- i_min_cnt_h = 0: no shift; reduction only.
- Counter wrap and a new frame on consecutive cycles: no gap is required. The index goes 31 then 0 back-to-back, with o_last high only on 31.
- Outputs hold their last values while o_valid=0.

## Configuration
- CBFP_ROUND_EN defined:
  - Reduction is round-half-up: (x + 2^(D-1)) >>> D, computed at IN_W+1 bits.
  - Positive overflow saturates to 2^(OUT_W-1)-1.
  - Negative results cannot overflow.
- CBFP_ROUND_EN undefined: plain truncation, with no adder and no saturation logic.
- Shift, exponent, latency and counter behaviour are identical in both builds.

## Test plan
All scenarios use the default parameters; D = 14.
- **Clamped shift:** lane0 re=1 with i_min_cnt_0=23 -> o_exp_0=14, o_data_re[0]=1, output 2 cycles after i_valid.
- **Per-half shifts:** lane0 re=-4096 with cnt0=12, and lane8 re=-4096 with cnt1=0.
  - Lane 0 -> o_data_re[0]=-1024, o_exp_0=12.
  - Lane 8 -> o_data_re[8]=-1 in the truncation build, 0 with CBFP_ROUND_EN.
- **Rounding and saturation, shift 0:**
  - re=8192: truncation -> 0; rounding -> 1.
  - re=2^24-1: truncation -> 1023; rounding -> saturates to 1023.
  - re=-1: truncation -> -1; rounding -> 0.
- **Frame counter:**
  - 64 consecutive valid beats -> o_blk_idx runs 0..31 twice, and o_last pulses on the 32nd and 64th outputs.
  - Random i_valid gaps do not advance the index.
- **Reset mid-frame:**
  - Assert rst during beat 10 with 2 beats in flight -> outputs 0 immediately and no in-flight beat emerges.
  - The next input yields o_blk_idx=0.
- **Sign and back-to-back coverage:** random full-scale data with random counts no greater than the true redundant sign bits. Outputs match a reference model bit-exactly on back-to-back beats.
